attack_scheduler: RTL

//  Game-level sequencer for the attacker instances of the 1024x768 @ 65 MHz dodge game. Arms and clears the

---
 rtl/dhd_game_pkg.sv | 33 +++
 rtl/frame_timer.sv | 32 +++
 rtl/attack_scheduler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dhd_game_pkg.sv
// Shared constants and types for the dodge game: XGA timing, walls, scheduler states.
// Pure declarations; no latency or backpressure of its own.
package dhd_game_pkg;

  localparam int H_VIS = 1024;
  localparam int HFP   = 24;
  localparam int HSP   = 136;
  localparam int HBP   = 160;
  localparam int V_VIS = 768;
  localparam int VFP   = 3;
  localparam int VSP   = 6;
  localparam int VBP   = 29;

  localparam int LEFT_WALL   = 20;
  localparam int RIGHT_WALL  = 1004;
  localparam int TOP_WALL    = 20;
  localparam int BOTTOM_WALL = 748;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    PLAY = 2'd2,
    OVER = 2'd3
  } sched_state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame-tick detector plus loadable down-counter; done pulses on the tick that takes it 1->0.
// Load has priority over counting; no backpressure.
module frame_timer #(
  parameter int CW = 8
) (
  input  logic          clk_65M,
  input  logic          clear_n,
  input  logic [16:0]   H_count,
  input  logic [16:0]   V_count,
  input  logic          run,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt;
  logic          frame_tick;

  assign frame_tick = (H_count == 17'd0) && (V_count == 17'd0);
  assign done       = run && frame_tick && (cnt == CW'(1));

  always_ff @(posedge clk_65M or negedge clear_n) begin
    if (!clear_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (run && frame_tick && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/attack_scheduler.sv
// Game sequencer: arms attackers, staggers their release, scores dodges, detects hits.
// All outputs registered, one cycle from input event; no backpressure.
module attack_scheduler
  import dhd_game_pkg::*;
#(
  parameter int N_ATK      = 5,
  parameter int ARM_FRAMES = 30,
  parameter int LAUNCH_GAP = 20,
  parameter int LEVEL_PTS  = 10,
  parameter int MAX_LEVEL  = 7
) (
  input  logic             clk_65M,
  input  logic             clear_n,
  input  logic             game_start,
  input  logic [16:0]      H_count,
  input  logic [16:0]      V_count,
  input  logic [N_ATK-1:0] atk_over,
  input  logic [N_ATK-1:0] atk_wrap,
  output logic             game_stop,
  output logic [N_ATK-1:0] atk_en,
  output logic             game_on,
  output logic             game_over,
  output logic [15:0]      score,
  output logic [2:0]       level
);

  sched_state_t     state, state_nxt;
  logic             stop_nxt, on_nxt, over_nxt;
  logic [N_ATK-1:0] en_nxt;
  logic [15:0]      score_nxt;
  logic [2:0]       level_nxt;
  logic [7:0]       pts_mod, pts_nxt;

  logic             timer_run, timer_load, timer_done;
  logic [7:0]       timer_val;

  logic             hit;
  logic [3:0]       wrap_pop;
  logic [16:0]      score_sum;
  logic [8:0]       pts_sum;

  frame_timer #(.CW(8)) u_timer (
    .clk_65M  (clk_65M),
    .clear_n  (clear_n),
    .H_count  (H_count),
    .V_count  (V_count),
    .run      (timer_run),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // Only released attackers may score or end the game.
  assign hit       = |(atk_over & atk_en);
  assign wrap_pop  = popcount8(8'(atk_wrap & atk_en));
  assign score_sum = {1'b0, score} + {13'd0, wrap_pop};
  assign pts_sum   = {1'b0, pts_mod} + {5'd0, wrap_pop};

  always_comb begin
    state_nxt  = state;
    stop_nxt   = game_stop;
    en_nxt     = atk_en;
    on_nxt     = game_on;
    over_nxt   = game_over;
    score_nxt  = score;
    level_nxt  = level;
    pts_nxt    = pts_mod;
    timer_run  = 1'b0;
    timer_load = 1'b0;
    timer_val  = 8'(ARM_FRAMES);

    case (state)
      IDLE, OVER: begin
        stop_nxt = (state == IDLE);
        if (game_start) begin
          state_nxt  = ARM;
          stop_nxt   = 1'b1;
          en_nxt     = '0;
          on_nxt     = 1'b0;
          over_nxt   = 1'b0;
          score_nxt  = '0;
          level_nxt  = '0;
          pts_nxt    = '0;
          timer_load = 1'b1;
        end
      end
      ARM: begin
        stop_nxt  = 1'b1;
        en_nxt    = '0;
        timer_run = 1'b1;
        if (timer_done) begin
          state_nxt  = PLAY;
          stop_nxt   = 1'b0;
          on_nxt     = 1'b1;
          en_nxt     = N_ATK'(1);
          timer_load = 1'b1;
          timer_val  = 8'(LAUNCH_GAP);
        end
      end
      PLAY: begin
        stop_nxt  = 1'b0;
        timer_run = 1'b1;
        if (hit) begin
          state_nxt = OVER;
          on_nxt    = 1'b0;
          over_nxt  = 1'b1;
        end else begin
          if (timer_done) begin
            timer_load = 1'b1;
            timer_val  = 8'(LAUNCH_GAP);
            if (!(&atk_en)) en_nxt = (atk_en << 1) | N_ATK'(1);
          end
          score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          // pts_mod wraps at LEVEL_PTS so one cycle bumps level at most once.
          if (pts_sum >= 9'(LEVEL_PTS)) begin
            pts_nxt = 8'(pts_sum - 9'(LEVEL_PTS));
            if (level != 3'(MAX_LEVEL)) level_nxt = level + 3'd1;
          end else begin
            pts_nxt = pts_sum[7:0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_65M or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      game_stop <= 1'b1;
      atk_en    <= '0;
      game_on   <= 1'b0;
      game_over <= 1'b0;
      score     <= '0;
      level     <= '0;
      pts_mod   <= '0;
    end else begin
      state     <= state_nxt;
      game_stop <= stop_nxt;
      atk_en    <= en_nxt;
      game_on   <= on_nxt;
      game_over <= over_nxt;
      score     <= score_nxt;
      level     <= level_nxt;
      pts_mod   <= pts_nxt;
    end
  end

endmodule
